param_fetch_ctrl: RTL and testbench
===================================

PARAM_FETCH_CTRL -- requirements
Module: param_fetch_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 5, meaning the number of parameter words fetched per start.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the width of the SRAM word address.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the width of an SRAM word.
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst  in  1  reset: asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to fetch all parameters.
REQ-007 SHALL have port load_valid  in  1  host write request.
REQ-008 SHALL have port load_ready  out  1  host write accepted this cycle.
REQ-009 SHALL have port load_addr  in  ADDR_W  host write word address.
REQ-010 SHALL have port load_data  in  DATA_W  host write data.
REQ-011 SHALL have port mem  sp_ram_intf  -  SRAM initiator side: drives cs, oe, addr, W_req (active-low write), W_data; receives R_data.
REQ-012 SHALL have port params  out  WORDS x DATA_W  fetched parameter registers, where params[k] holds word k.
REQ-013 SHALL have port params_valid  out  1  params hold a complete, current fetch.
REQ-014 SHALL have port busy  out  1  a fetch is in progress.
REQ-015 SHALL have port done  out  1  one-cycle pulse marking fetch completion.
REQ-016 SHALL have port addr_err  out  1  sticky flag for an out-of-range host write.

Function
REQ-017 SHALL implement the states IDLE, READ, DRAIN, DONE.
REQ-018 SHALL move from IDLE to READ, clearing the address counter, when start=1 is sampled in IDLE.
REQ-019 SHALL ignore start while not in IDLE.
REQ-020 SHALL, in READ, drive cs=1, oe=1, W_req=1, addr=counter, and increment the counter every cycle.
REQ-021 SHALL move from READ to DRAIN after the cycle that issued address WORDS-1.
REQ-022 SHALL, in the cycle after address k is issued, capture R_data into params[k] at the next clock edge (SRAM read latency of one cycle).
REQ-023 SHALL, in DRAIN, drive cs=0 and oe=1, capture the final word, and move to DONE.
REQ-024 SHALL, in DONE, assert done=1 for one cycle, set params_valid=1 and return to IDLE.
REQ-025 SHALL assert done WORDS+1 cycles after the edge that sampled start.
REQ-026 SHALL assert busy=1 in READ, DRAIN and DONE.
REQ-027 SHALL drive load_ready = (state==IDLE) & ~start, so that start has priority over a simultaneous load.
REQ-028 SHALL, on an accepted load with load_addr<WORDS, drive in the same cycle cs=1, W_req=0, oe=0, addr=load_addr, W_data=load_data.
REQ-029 SHALL accept and drop a load with load_addr>=WORDS (cs=0), set addr_err=1, and hold addr_err until reset.
REQ-030 SHALL clear params_valid on any accepted in-range load, because the params are then stale.
REQ-031 SHALL, when idle with no load, drive cs=0, oe=0, W_req=1, addr=0, W_data=0.
REQ-032 SHALL leave params unchanged outside fetch captures.

Reset
REQ-033 SHALL, while rst is asserted, force state to IDLE and set counter, params, params_valid, done, busy and addr_err to 0.
REQ-034 SHALL, on rst asserted mid-fetch, abort the fetch with no done pulse and leave params at 0.

Structure
REQ-035 SHALL place the state enum and the WORDS/ADDR_W/DATA_W defaults in the shared EPU package.
REQ-036 SHALL be a single module with no sub-modules, taking the SRAM through the sp_ram_intf initiator modport.

Verification
REQ-037 SHALL cover: preload SRAM words 0..4 = 0x11,0x22,0x33,0x44,0x55, then pulse start -> params = those values, done exactly 6 cycles after the start edge, params_valid=1.
REQ-038 SHALL cover: start held high for 3 cycles -> exactly one fetch and one done pulse.
REQ-039 SHALL cover: start and load_valid high together in IDLE -> load_ready=0, no write, fetch begins.
REQ-040 SHALL cover: load to address 6 -> accepted, no SRAM cs, addr_err=1 until reset.
REQ-041 SHALL cover: fetch completes, then load word 2 = 0xAB -> params_valid=0; refetch -> params[2]=0xAB, params_valid=1.
REQ-042 SHALL cover: rst asserted during READ at counter=2 -> all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/param_fetch_ctrl_pkg.sv
// Shared definitions for the parameter fetch controller: FSM state encoding
// and default geometry of the parameter SRAM.
package param_fetch_ctrl_pkg;

  localparam int DEF_WORDS  = 5;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM bus: cs/oe strobes, active-low write request, and
// read data returned one cycle after the address.
interface sp_ram_intf
  import param_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cs;
  logic              oe;
  logic              W_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] W_data;
  logic [DATA_W-1:0] R_data;

  modport initiator (output cs, oe, addr, W_req, W_data, input R_data);
  modport target    (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/param_fetch_ctrl.sv
// Parameter fetch controller: lets a host preload parameter words into the
// SRAM, and on start streams all WORDS words back into parallel registers.
module param_fetch_ctrl
  import param_fetch_ctrl_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  sp_ram_intf.initiator                 mem,
  output logic [WORDS-1:0][DATA_W-1:0]  params,
  output logic                          params_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          addr_err
);

  // Counter must reach WORDS (not just WORDS-1) so DRAIN can name the last word.
  localparam int CNT_W = $clog2(WORDS + 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_in_range;
  logic              load_acc;
  logic              cs_d, oe_d, wreq_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign load_in_range = ({1'b0, load_addr} < (ADDR_W + 1)'(WORDS));
  assign load_acc      = load_valid & load_ready;

  assign mem.cs     = cs_d;
  assign mem.oe     = oe_d;
  assign mem.W_req  = wreq_d;
  assign mem.addr   = addr_d;
  assign mem.W_data = wdata_d;

  // State register and read address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        cnt_q <= '0;
      else if (state_q == READ)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next state, SRAM bus drive and status decode.
  always_comb begin
    state_d    = state_q;
    cs_d       = 1'b0;
    oe_d       = 1'b0;
    wreq_d     = 1'b1;
    addr_d     = '0;
    wdata_d    = '0;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = ~start;
        if (start) begin
          state_d = READ;
        end else if (load_valid && load_in_range) begin
          cs_d    = 1'b1;
          wreq_d  = 1'b0;
          addr_d  = load_addr;
          wdata_d = load_data;
        end
      end
      READ: begin
        busy   = 1'b1;
        cs_d   = 1'b1;
        oe_d   = 1'b1;
        addr_d = ADDR_W'(cnt_q);
        if (cnt_q == CNT_W'(WORDS - 1))
          state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        oe_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture read data and maintain the valid / error flags.
  // Read data lags the address by one cycle, so while the counter holds k+1
  // the bus carries word k; DRAIN (counter==WORDS) catches the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      params       <= '0;
      params_valid <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      if (state_q == READ || state_q == DRAIN) begin
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (cnt_q == CNT_W'(k + 1))
            params[k] <= mem.R_data;
        end
      end
      if (state_q == DRAIN)
        params_valid <= 1'b1;
      else if (load_acc && load_in_range)
        params_valid <= 1'b0;
      if (load_acc && !load_in_range)
        addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_fetch_ctrl.sv
// Scoreboard bench for param_fetch_ctrl: stimulus pushes expected fetch
// results, a monitor pops and compares whenever done is presented.
module tb_param_fetch_ctrl;

  localparam int WORDS  = 5;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  typedef logic [WORDS-1:0][DATA_W-1:0] pvec_t;
  typedef struct {
    pvec_t       p;
    int unsigned cyc;
  } exp_t;

  logic              clk, rst, start, load_valid, load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  pvec_t             params;
  logic              params_valid, busy, done, addr_err;

  sp_ram_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  param_fetch_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .mem(mem_if),
    .params(params), .params_valid(params_valid),
    .busy(busy), .done(done), .addr_err(addr_err)
  );

  // SRAM fixture: write on cs & ~W_req, registered read on cs & oe & W_req.
  logic [DATA_W-1:0] sram [0:7];
  always @(posedge clk) begin
    if (mem_if.cs && !mem_if.W_req) sram[mem_if.addr] <= mem_if.W_data;
    if (mem_if.cs && mem_if.oe && mem_if.W_req) mem_if.R_data <= sram[mem_if.addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:WORDS-1];
  pvec_t last_p;
  bit    exp_pv, exp_err;
  exp_t  sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_latency", cyc, e.cyc);
        for (int k = 0; k < WORDS; k++) check($sformatf("param%0d", k), params[k], e.p[k]);
        check("pv_at_done", params_valid, 1);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) @(posedge clk);
    check("idle_timeout", busy, 0);
  endtask

  task automatic check_params_held(input string name);
    for (int k = 0; k < WORDS; k++) check($sformatf("%s%0d", name, k), params[k], last_p[k]);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bit inr;
    inr = (int'(la) < WORDS);
    wait_idle();
    @(posedge clk); #1;
    load_valid = 1'b1; load_addr = la; load_data = ld;
    @(negedge clk);
    check("load_ready_idle", load_ready, 1);
    check("load_cs", mem_if.cs, inr);
    if (inr) begin
      check("load_wreq", mem_if.W_req, 0);
      check("load_oe", mem_if.oe, 0);
      check("load_addr", mem_if.addr, la);
      check("load_wdata", mem_if.W_data, ld);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (inr) begin
      ref_mem[la] = ld;
      exp_pv = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    check("pv_after_load", params_valid, exp_pv);
    check("addr_err", addr_err, exp_err);
    check_params_held("held_param");
  endtask

  task automatic do_fetch(input int hold, input bit with_load,
                          input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    if (with_load) begin
      load_valid = 1'b1; load_addr = la; load_data = ld;
    end
    @(negedge clk);
    check("load_ready_start", load_ready, 0);
    if (with_load) check("cs_start_load", mem_if.cs, 0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < WORDS; k++) e.p[k] = ref_mem[k];
    e.cyc = cyc + WORDS + 1;
    sb.push_back(e);
    check("busy_after_start", busy, 1);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("done_timeout", sb.size(), 0);
    #1;
    exp_pv = 1'b1;
    last_p = e.p;
    check("pv_after_fetch", params_valid, 1);
    // a lingering start must not launch a second fetch
    repeat (3) @(posedge clk);
    #1 check("busy_after_done", busy, 0);
  endtask

  task automatic reset_mid_fetch();
    wait_idle();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rd_addr_before_rst", mem_if.addr, 2);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pv", params_valid, 0);
    check("rst_err", addr_err, 0);
    check("rst_cs", mem_if.cs, 0);
    check("rst_params", params, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_pv = 1'b0; exp_err = 1'b0; last_p = '0;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_ready", load_ready, 1);
    check("post_rst_params", params, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 8; i++) sram[i] = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    last_p = '0; exp_pv = 1'b0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pv", params_valid, 0);
    check("reset_err", addr_err, 0);
    check("reset_params", params, 0);
    check("reset_cs", mem_if.cs, 0);
    #1 rst = 1'b0;

    for (int i = 0; i < WORDS; i++) do_load(ADDR_W'(i), DATA_W'(32'h11 * (i + 1)));
    do_fetch(1, 1'b0, '0, '0);
    do_fetch(3, 1'b0, '0, '0);
    do_fetch(1, 1'b1, 3'd1, 32'h99);
    do_load(3'd6, 32'hDEAD);
    do_load(3'd2, 32'hAB);
    do_fetch(1, 1'b0, '0, '0);
    check("addr_err_sticky", addr_err, 1);

    for (int n = 0; n < 30; n++) begin
      int unsigned op;
      op = $urandom_range(0, 4);
      if (op <= 2) do_load(ADDR_W'($urandom_range(0, 7)), $urandom);
      else if (op == 3) do_fetch(int'($urandom_range(1, 3)), 1'b0, '0, '0);
      else do_fetch(1, 1'b1, ADDR_W'($urandom_range(0, 7)), $urandom);
    end
    do_fetch(1, 1'b0, '0, '0);

    reset_mid_fetch();
    do_fetch(1, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
